// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl
//   Drives the fetch stage's flow-change and stall inputs. Decode metadata is
//   captured into an ID/EX control register. Conditional branches resolve in
//   EX against a registered Z/V/N flag set. The block also detects load-use
//   hazards and sequences a processor halt through two drain cycles.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 IM/ID holds a real instruction (not a bubble)
//   id_br / id_jmp           conditional branch / unconditional jump
//   id_cond[2:0]             branch condition code
//   id_target[15:0]          resolved branch/jump destination
//   id_hlt / id_load         halt / load instruction
//   id_rd, id_rs, id_rt      destination and source register specifiers
//   id_uses_rs, id_uses_rt   source register actually read
//   ex_flags_we              instruction in EX updates the flags
//   ex_z, ex_v, ex_n         ALU flags from EX
//   flow_change_ID_EX        fetch takes dst_ID_EX next cycle
//   dst_ID_EX[15:0]          redirect target
//   stall                    hold PC and IM/ID
//   flush                    kill IM/ID contents
//   halted                   processor stopped
module branch_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_br,
  input  logic        id_jmp,
  input  logic [2:0]  id_cond,
  input  logic [15:0] id_target,
  input  logic        id_hlt,
  input  logic        id_load,
  input  logic [3:0]  id_rd,
  input  logic [3:0]  id_rs,
  input  logic [3:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_flags_we,
  input  logic        ex_z,
  input  logic        ex_v,
  input  logic        ex_n,
  output logic        flow_change_ID_EX,
  output logic [15:0] dst_ID_EX,
  output logic        stall,
  output logic        flush,
  output logic        halted
);

  typedef enum logic [1:0] {RUN, DRAIN1, DRAIN2, HALTED} state_t;

  state_t      state, state_nxt;

  logic        idex_v, idex_br, idex_jmp, idex_hlt, idex_load;
  logic [2:0]  idex_cond;
  logic [15:0] idex_target;
  logic [3:0]  idex_rd;

  logic        flag_z, flag_v, flag_n;
  logic        cond_met, taken, load_hazard;

  // ID/EX control register and flag register. Fields other than v load every
  // edge; v alone decides whether the entry is a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_v      <= 1'b0;
      idex_br     <= 1'b0;
      idex_jmp    <= 1'b0;
      idex_hlt    <= 1'b0;
      idex_load   <= 1'b0;
      idex_cond   <= '0;
      idex_target <= '0;
      idex_rd     <= '0;
      flag_z      <= 1'b0;
      flag_v      <= 1'b0;
      flag_n      <= 1'b0;
    end else begin
      idex_v      <= id_valid & ~stall & ~flush;
      idex_br     <= id_br;
      idex_jmp    <= id_jmp;
      idex_hlt    <= id_hlt;
      idex_load   <= id_load;
      idex_cond   <= id_cond;
      idex_target <= id_target;
      idex_rd     <= id_rd;
      if (ex_flags_we) begin
        flag_z <= ex_z;
        flag_v <= ex_v;
        flag_n <= ex_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    cond_met = 1'b0;
    case (idex_cond)
      3'b000:  cond_met = ~flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = ~flag_z & ~flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = ~flag_n;
      3'b101:  cond_met = flag_z | flag_n;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  assign taken = idex_v & (idex_jmp | (idex_br & cond_met));

  assign load_hazard = id_valid & idex_v & idex_load & (idex_rd != 4'd0) &
                       ((id_uses_rs & (id_rs == idex_rd)) |
                        (id_uses_rt & (id_rt == idex_rd)));

  // Halt states dominate; in RUN a taken flow change suppresses the load-use
  // stall because the dependent instruction is being flushed anyway.
  always_comb begin
    state_nxt         = state;
    flow_change_ID_EX = 1'b0;
    stall             = 1'b0;
    halted            = 1'b0;
    case (state)
      RUN: begin
        flow_change_ID_EX = taken;
        if (idex_v & idex_hlt) begin
          state_nxt = DRAIN1;
          stall     = 1'b1;
        end else begin
          stall = load_hazard & ~taken;
        end
      end
      DRAIN1: begin
        stall     = 1'b1;
        state_nxt = DRAIN2;
      end
      DRAIN2: begin
        stall     = 1'b1;
        state_nxt = HALTED;
      end
      HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush     = flow_change_ID_EX;
  assign dst_ID_EX = idex_target;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_br, id_jmp, id_hlt, id_load;
  logic [2:0]  id_cond;
  logic [15:0] id_target;
  logic [3:0]  id_rd, id_rs, id_rt;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_flags_we, ex_z, ex_v, ex_n;
  logic        flow_change_ID_EX;
  logic [15:0] dst_ID_EX;
  logic        stall, flush, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_br             (id_br),
    .id_jmp            (id_jmp),
    .id_cond           (id_cond),
    .id_target         (id_target),
    .id_hlt            (id_hlt),
    .id_load           (id_load),
    .id_rd             (id_rd),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_uses_rs        (id_uses_rs),
    .id_uses_rt        (id_uses_rt),
    .ex_flags_we       (ex_flags_we),
    .ex_z              (ex_z),
    .ex_v              (ex_v),
    .ex_n              (ex_n),
    .flow_change_ID_EX (flow_change_ID_EX),
    .dst_ID_EX         (dst_ID_EX),
    .stall             (stall),
    .flush             (flush),
    .halted            (halted)
  );

  // One record per cycle: IM/ID contents and EX flag inputs during the cycle,
  // plus the outputs expected in that same cycle.
  typedef struct {
    logic        valid, br, jmp;
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic        hlt, load;
    logic [3:0]  rd, rs, rt;
    logic        urs, urt;
    logic        fwe, z, v, n;
    logic        e_fc;
    logic [15:0] e_dst;
    logic        e_stall, e_flush, e_halted;
  } vec_t;

  vec_t vecs[$];

  // flg = {we, z, v, n}; ex = {flow_change, stall, flush, halted}
  function automatic vec_t row(logic valid, logic br, logic jmp, logic [2:0] cond,
                               logic [15:0] tgt, logic hlt, logic load,
                               logic [3:0] rd, logic [3:0] rs, logic [3:0] rt,
                               logic urs, logic urt, logic [3:0] flg,
                               logic [15:0] e_dst, logic [3:0] ex);
    vec_t r;
    r.valid = valid; r.br = br; r.jmp = jmp; r.cond = cond; r.tgt = tgt;
    r.hlt = hlt; r.load = load; r.rd = rd; r.rs = rs; r.rt = rt;
    r.urs = urs; r.urt = urt;
    r.fwe = flg[3]; r.z = flg[2]; r.v = flg[1]; r.n = flg[0];
    r.e_dst = e_dst;
    r.e_fc = ex[3]; r.e_stall = ex[2]; r.e_flush = ex[1]; r.e_halted = ex[0];
    return r;
  endfunction

  task automatic drive(input vec_t r);
    id_valid = r.valid; id_br = r.br; id_jmp = r.jmp; id_cond = r.cond;
    id_target = r.tgt; id_hlt = r.hlt; id_load = r.load;
    id_rd = r.rd; id_rs = r.rs; id_rt = r.rt;
    id_uses_rs = r.urs; id_uses_rt = r.urt;
    ex_flags_we = r.fwe; ex_z = r.z; ex_v = r.v; ex_n = r.n;
  endtask

  task automatic check(input string name, input logic fc, input logic [15:0] dst,
                       input logic st, input logic fl, input logic hl);
    checks++;
    if (flow_change_ID_EX !== fc || dst_ID_EX !== dst || stall !== st ||
        flush !== fl || halted !== hl) begin
      errors++;
      $display("FAIL %s: got fc=%b dst=%h stall=%b flush=%b halted=%b, want fc=%b dst=%h stall=%b flush=%b halted=%b",
               name, flow_change_ID_EX, dst_ID_EX, stall, flush, halted,
               fc, dst, st, fl, hl);
    end
  endtask

  vec_t idle, hv, yv;

  initial begin
    idle = row(0,0,0,3'd0,16'h0000,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000);
    drive(idle);
    rst = 1'b1;

    // EQ branch taken (Z=1)
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd1,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,1,0,3'd1,16'h0040,0,0,4'd0,4'd0,4'd0,0,0,4'b1100,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd2,4'd0,4'd0,0,0,4'b0000,16'h0040,4'b1010));
    vecs.push_back(row(0,0,0,3'd0,16'h0000,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    // EQ branch not taken (Z=0)
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd1,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,1,0,3'd1,16'h0040,0,0,4'd0,4'd0,4'd0,0,0,4'b1000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd2,4'd0,4'd0,0,0,4'b0000,16'h0040,4'b0000));
    // Load rd=5 then rs=5 reader: one stall cycle, reader held in IM/ID
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,1,4'd5,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd6,4'd5,4'd0,1,0,4'b0000,16'h0000,4'b0100));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd6,4'd5,4'd0,1,0,4'b0000,16'h0000,4'b0000));
    // Load rd=0: never a hazard
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,1,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd6,4'd0,4'd0,1,0,4'b0000,16'h0000,4'b0000));
    // Hazard through rt only
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,1,4'd7,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd8,4'd7,4'd7,0,1,4'b0000,16'h0000,4'b0100));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd8,4'd7,4'd7,0,1,4'b0000,16'h0000,4'b0000));
    // Matching specifiers but not read: no hazard
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,1,4'd3,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd8,4'd3,4'd3,0,0,4'b0000,16'h0000,4'b0000));
    // UNC flow change in ID/EX beats load-use stall
    vecs.push_back(row(1,1,0,3'd7,16'h0100,0,1,4'd4,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd6,4'd4,4'd0,1,0,4'b0000,16'h0100,4'b1010));
    vecs.push_back(row(0,0,0,3'd0,16'h0000,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    // LT uses old flags while new flags are written; following GT is flushed
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd1,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,1,0,3'd3,16'h0200,0,0,4'd0,4'd0,4'd0,0,0,4'b1011,16'h0000,4'b0000));
    vecs.push_back(row(1,1,0,3'd2,16'h0300,0,0,4'd0,4'd0,4'd0,0,0,4'b1000,16'h0200,4'b1010));
    vecs.push_back(row(1,1,0,3'd6,16'h0400,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0300,4'b0000));
    // OVF not taken (V=0), then jal taken
    vecs.push_back(row(1,0,1,3'd0,16'h0500,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0400,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd2,4'd0,4'd0,0,0,4'b0000,16'h0500,4'b1010));
    vecs.push_back(row(0,0,0,3'd0,16'h0000,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    // Halt behind a taken jump is flushed
    vecs.push_back(row(1,0,1,3'd0,16'h0600,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,1,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0600,4'b1010));
    vecs.push_back(row(0,0,0,3'd0,16'h0000,0,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd1,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));
    vecs.push_back(row(1,0,0,3'd0,16'h0000,0,0,4'd2,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000));

    // Reset state and idle cycles
    #2;
    check("reset_active", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(idle);
      #1;
      check($sformatf("idle_%0d", i), 0, 16'h0000, 0, 0, 0);
    end

    // Table-driven sequence
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec_%0d", i), vecs[i].e_fc, vecs[i].e_dst, vecs[i].e_stall,
            vecs[i].e_flush, vecs[i].e_halted);
    end

    // Halt sequence: hlt enters ID/EX at cycle t
    hv = row(1,0,0,3'd0,16'h0000,1,0,4'd0,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000);
    yv = row(1,0,1,3'd0,16'h0700,0,0,4'd2,4'd0,4'd0,0,0,4'b0000,16'h0000,4'b0000);
    @(negedge clk); drive(hv); #1;
    check("halt_in_id", 0, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(yv); #1;
    check("halt_t", 0, 16'h0000, 1, 0, 0);
    @(negedge clk); #1;
    check("halt_t1_drain1", 0, 16'h0700, 1, 0, 0);
    @(negedge clk); #1;
    check("halt_t2_drain2", 0, 16'h0700, 1, 0, 0);
    @(negedge clk); #1;
    check("halt_t3_halted", 0, 16'h0700, 1, 0, 1);
    @(negedge clk); #1;
    check("halt_t4_held", 0, 16'h0700, 1, 0, 1);

    // Asynchronous reset mid-cycle at t+5
    @(negedge clk); #1;
    check("halt_t5_held", 0, 16'h0700, 1, 0, 1);
    rst = 1'b1;
    #1;
    check("async_reset_from_halted", 0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    @(negedge clk); #1;
    check("run_after_reset", 0, 16'h0000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Control block that drives the fetch stage's flow-change and stall inputs. It captures branch, jump, halt and load metadata from decode into its own ID/EX control register. It resolves conditional branches in EX against a registered Z/V/N flag set, detects load-use hazards, and sequences processor halt. Outputs go straight to the program counter / fetch pipeline: `flow_change_ID_EX`, `dst_ID_EX`, `stall`, and the flush and halted indications.

## Interface
- No parameters. Datapath width is fixed at 16 bits; register specifiers are 4 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  instruction in IM/ID is real, not a bubble
- id_br  in  1  conditional branch
- id_jmp  in  1  unconditional jump (jal/jr)
- id_cond  in  3  branch condition code
- id_target  in  16  resolved branch/jump destination
- id_hlt  in  1  halt instruction
- id_load  in  1  load instruction
- id_rd  in  4  destination register
- id_rs, id_rt  in  4 each  source registers
- id_uses_rs, id_uses_rt  in  1 each  source actually read
- ex_flags_we  in  1  instruction in EX updates flags
- ex_z, ex_v, ex_n  in  1 each  ALU flags from EX
- flow_change_ID_EX  out  1  fetch takes `dst_ID_EX` next cycle
- dst_ID_EX  out  16  redirect target
- stall  out  1  hold PC and IM/ID
- flush  out  1  kill IM/ID contents; IM/ID becomes a bubble
- halted  out  1  processor stopped

## Operation
- ID/EX control register holds v, br, jmp, cond, target, hlt, load, rd.
  - Each edge it loads the id_* fields, with v = id_valid & !stall & !flush.
  - When v = 0, all other fields are don't-care, but they still load.
- Flag register {Z,V,N} loads {ex_z,ex_v,ex_n} on edges where ex_flags_we = 1.
  - A branch in ID/EX is evaluated against the flag register. This register holds the flags of the instruction immediately ahead of the branch.
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GTE: !N
  - 101 LTE: Z|N
  - 110 OVF: V
  - 111 UNC: always
- taken = v & (jmp | (br & cond_met)).
- flow_change_ID_EX = taken & state==RUN (combinational).
- dst_ID_EX = registered target; it is valid whenever flow_change_ID_EX = 1.
- flush = flow_change_ID_EX. This kills the instruction in IM/ID; the next ID/EX load is a bubble.
- Load-use stall (RUN only) = id_valid & v & load & rd!=0 & ((id_uses_rs & id_rs==rd) | (id_uses_rt & id_rt==rd)) & !flow_change_ID_EX.
- Priority, highest first: halt states, then flow change, then load-use stall.
  - Flow change suppresses the stall in the same cycle.
- Halt FSM:
  - RUN: when v & hlt in ID/EX, go to DRAIN1. stall = 1 from that cycle onward.
  - DRAIN1 → DRAIN2 → HALTED, advancing unconditionally, to let DM and WB retire older instructions.
  - HALTED: halted = 1, stall = 1, flow_change = 0. Stays here until rst.
- A halt in IM/ID behind a taken branch is flushed and never reaches ID/EX.

## Timing
- Reset values:
  - state RUN; flags 000; ID/EX v = 0; target = 0.
  - Outputs: stall = 0, flow_change_ID_EX = 0, dst_ID_EX = 0x0000, flush = 0, halted = 0.
- Branch penalty: 2 cycles.
  - The branch is in ID/EX at cycle t and flow_change is asserted in t.
  - The PC loads the target at edge t+1.
  - The instruction fetched in t is flushed; the instruction already in IM/ID is flushed via flush at t.
- Load-use stall:
  - stall is high for exactly 1 cycle.
  - The next cycle the load has left ID/EX (a bubble is inserted), so the condition clears.
- Flag write and branch evaluation in the same cycle: the branch uses the old (registered) flags.
  - The new flags become visible to the next instruction.
- Halt latency:
  - hlt in ID/EX at cycle t → stall in t.
  - state DRAIN1 at t+1, DRAIN2 at t+2, HALTED (halted = 1) at t+3.
- Reset asserted mid-operation, including DRAIN or HALTED: all state clears immediately and asynchronously to the reset values above.
- Back-to-back taken branches: the second is always flushed, because of the flush issued by the first.

## Test plan
- Reset: rst pulse → all outputs 0, dst_ID_EX = 0x0000; halted stays 0 over 10 idle cycles.
- Conditional branches:
  - ALU op sets Z=1 (ex_flags_we=1), next instruction is EQ branch to 0x0040 → flow_change = 1, dst = 0x0040, flush = 1 for one cycle.
  - Same sequence with Z=0 → no flow_change.
- Load-use hazard:
  - Load rd=5 followed by add reading rs=5 → stall = 1 for exactly 1 cycle, and the ID/EX bubble has v = 0.
  - Same sequence with rd=0 → no stall.
- Flow change beats stall: a taken UNC jump in ID/EX while IM/ID holds a load-dependent instruction → flush = 1, stall = 0.
- Halt:
  - hlt in ID/EX at cycle t → stall from t onward; halted = 1 at t+3 and held.
  - rst at t+5 → back to RUN with all outputs 0.
- Halt behind a taken branch: the halt is flushed and never halts the processor; execution continues at the target.
